// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - 4-bit ALU operation codes presented to the ALU (OP_INVALID makes the ALU yield 0)
//   - 3-bit main-control ALUOp type codes
//   - R-type funct field constants
//   - decode_alu_op(): ALUOp type + funct -> ALU operation code
package alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_NOR    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_LUI    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] OP_INVALID = 4'hF;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_LUI   = 3'b101;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;

    function automatic logic [3:0] decode_alu_op(input logic [2:0] op_type,
                                                 input logic [5:0] funct);
        logic [3:0] op;
        op = OP_INVALID;
        case (op_type)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_OR:  op = ALU_OR;
            ALUOP_AND: op = ALU_AND;
            ALUOP_LUI: op = ALU_LUI;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: op = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: op = ALU_SUB;
                    FUNCT_AND:             op = ALU_AND;
                    FUNCT_OR:              op = ALU_OR;
                    FUNCT_NOR:             op = ALU_NOR;
                    FUNCT_SLL:             op = ALU_SLL;
                    FUNCT_SRL:             op = ALU_SRL;
                    default:               op = OP_INVALID;
                endcase
            end
            default: op = OP_INVALID;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready.
// Ports:
//   clk, reset (sync, active-high), flush (sync clear of both entries)
//   in_valid/in_ready/in_data   : upstream handshake and payload
//   out_valid/out_ready/out_data: downstream handshake and payload (main entry)
// Parameters: PAYLOAD_W payload width, RESET_VAL payload value after reset/flush.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | no entry held, out_valid=0
// ST_ONE   | main entry presented, skid empty
// ST_FULL  | main entry presented, skid holds next entry, in_ready=0
module alu_issue_skid
    import alu_pkg::*;
#(
    parameter int unsigned             PAYLOAD_W = 8,
    parameter logic [PAYLOAD_W-1:0]    RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   main_q, main_d;
    logic [PAYLOAD_W-1:0]   skid_q, skid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   accept;
    logic                   retire;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        accept   = in_valid && in_ready_q;
        retire   = (state_q != ST_EMPTY) && out_ready;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && retire) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (retire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a retire can happen
                if (retire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end

        // Registered ready: derived from next state, so out_ready never
        // reaches in_ready combinationally.
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/alu_op_issue.sv
// ALU issue stage: decodes ALUOp type + R-type funct into the 4-bit ALU
// operation and queues it with operands A/B and shamt in a 2-entry skid
// buffer between ID decode and the EX pipeline register.
// Ports:
//   clk, reset (sync, active-high), flush (sync clear of buffered entries)
//   in_valid/in_ready, alu_op_type, funct, shamt_in, a_in, b_in : decode side
//   out_valid/out_ready, alu_operation, a_out, b_out, shamt_out : ALU side
// Optional feature macro ALU_ISSUE_ILLEGAL_EN adds:
//   illegal_op   : travels with each entry, 1 when decode produced OP_INVALID
//   illegal_seen : sticky, set on accept of an illegal entry, cleared only by reset
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         alu_op_type,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt_in,
    input  logic [DATA_W-1:0]  a_in,
    input  logic [DATA_W-1:0]  b_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alu_operation,
    output logic [DATA_W-1:0]  a_out,
    output logic [DATA_W-1:0]  b_out,
    output logic [SHAMT_W-1:0] shamt_out
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic               illegal_op,
    output logic               illegal_seen
`endif
);

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam int unsigned ILL_W = 1;
`else
    localparam int unsigned ILL_W = 0;
`endif
    localparam int unsigned PAYLOAD_W = 4 + 2 * DATA_W + SHAMT_W + ILL_W;
    // Operation code sits in the top bits so the reset value is simply F followed by zeros.
    localparam logic [PAYLOAD_W-1:0] RESET_VAL = {OP_INVALID, {(PAYLOAD_W-4){1'b0}}};

    logic [3:0]           dec_op;
    logic [PAYLOAD_W-1:0] in_data;
    logic [PAYLOAD_W-1:0] out_data;

    always_comb begin
        dec_op = decode_alu_op(alu_op_type, funct);
`ifdef ALU_ISSUE_ILLEGAL_EN
        in_data = {dec_op, a_in, b_in, shamt_in, (dec_op == OP_INVALID)};
`else
        in_data = {dec_op, a_in, b_in, shamt_in};
`endif
    end

    alu_issue_skid #(
        .PAYLOAD_W (PAYLOAD_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign {alu_operation, a_out, b_out, shamt_out, illegal_op} = out_data;

    logic illegal_seen_q, illegal_seen_d;

    // A flush cycle never accepts, so it cannot set the sticky flag; flush
    // does not clear it either.
    always_comb begin
        illegal_seen_d = illegal_seen_q
                       | (in_valid & in_ready & ~flush & (dec_op == OP_INVALID));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_seen = illegal_seen_q;
`else
    assign {alu_operation, a_out, b_out, shamt_out} = out_data;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_op_type = 3'b000;
    logic [5:0]  funct = 6'h00;
    logic [4:0]  shamt_in = 5'd0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_operation;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [4:0]  shamt_out;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic        illegal_op;
    logic        illegal_seen;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    exp_t cur_exp;

    alu_op_issue #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_op_type   (alu_op_type),
        .funct         (funct),
        .shamt_in      (shamt_in),
        .a_in          (a_in),
        .b_in          (b_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_operation (alu_operation),
        .a_out         (a_out),
        .b_out         (b_out),
        .shamt_out     (shamt_out)
`ifdef ALU_ISSUE_ILLEGAL_EN
        ,
        .illegal_op    (illegal_op),
        .illegal_seen  (illegal_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: monitor pops on retire, then queues the entry being accepted.
    always @(negedge clk) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: op=%0h a=%0h with empty scoreboard",
                             alu_operation, a_out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_op", {28'd0, alu_operation}, {28'd0, e.op});
                    chk("sb_a", a_out, e.a);
                    chk("sb_b", b_out, e.b);
                    chk("sb_shamt", {27'd0, shamt_out}, {27'd0, e.sh});
`ifdef ALU_ISSUE_ILLEGAL_EN
                    chk("sb_illegal_op", {31'd0, illegal_op}, {31'd0, (e.op == 4'hF)});
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic send(input logic [2:0] t, input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] eop);
        bit ok;
        ok = 1'b0;
        cur_exp.op = eop;
        cur_exp.a  = a;
        cur_exp.b  = b;
        cur_exp.sh = sh;
        alu_op_type = t;
        funct = f;
        shamt_in = sh;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %0h", eop);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // type, funct, shamt, a, b, expected op
    typedef struct {
        logic [2:0]  t;
        logic [5:0]  f;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  eop;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // 1: reset held two cycles
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_alu_operation", {28'd0, alu_operation}, 32'hF);
        chk("rst_a_out", a_out, 32'd0);
        chk("rst_b_out", b_out, 32'd0);
        chk("rst_shamt_out", {27'd0, shamt_out}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("rst_illegal_seen", {31'd0, illegal_seen}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // 2: R-type SUB, one-cycle latency
        out_ready = 1'b1;
        send(3'b010, 6'h22, 5'd0, 32'd7, 32'd3, 4'b0100);
        @(negedge clk);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_alu_operation", {28'd0, alu_operation}, 32'h4);
        chk("lat_a_out", a_out, 32'd7);
        chk("lat_b_out", b_out, 32'd3);
        @(posedge clk);
        #1;

        // 3: fill with out_ready low, then drain in order
        out_ready = 1'b0;
        send(3'b000, 6'h24, 5'd1, 32'h11, 32'h22, 4'b0011);
        send(3'b011, 6'h20, 5'd2, 32'h33, 32'h44, 4'b0001);
        fork
            send(3'b101, 6'h00, 5'd3, 32'h55, 32'h66, 4'b0101);
            begin
                @(negedge clk);
                chk("full_in_ready", {31'd0, in_ready}, 32'd0);
                chk("full_head_op", {28'd0, alu_operation}, 32'h3);
                @(negedge clk);
                chk("stall_head_stable", a_out, 32'h11);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        @(negedge clk);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // 4: shifts carry shamt through
        send(3'b010, 6'h00, 5'd4, 32'hA, 32'hB, 4'b0110);
        send(3'b010, 6'h02, 5'd31, 32'hC, 32'hD, 4'b0111);

        // decode coverage, streaming with out_ready high
        vecs = '{
            '{3'b001, 6'h20, 5'd0, 32'h1, 32'h2, 4'b0100},
            '{3'b100, 6'h25, 5'd0, 32'h3, 32'h4, 4'b0000},
            '{3'b110, 6'h20, 5'd0, 32'h5, 32'h6, 4'hF},
            '{3'b111, 6'h20, 5'd0, 32'h7, 32'h8, 4'hF},
            '{3'b010, 6'h20, 5'd9, 32'h9, 32'hA, 4'b0011},
            '{3'b010, 6'h21, 5'd0, 32'hB, 32'hC, 4'b0011},
            '{3'b010, 6'h23, 5'd0, 32'hD, 32'hE, 4'b0100},
            '{3'b010, 6'h24, 5'd0, 32'hF, 32'h10, 4'b0000},
            '{3'b010, 6'h25, 5'd0, 32'h11, 32'h12, 4'b0001},
            '{3'b010, 6'h27, 5'd0, 32'hFFFF_0000, 32'h0000_FFFF, 4'b0010},
            '{3'b010, 6'h03, 5'd0, 32'h13, 32'h14, 4'hF}
        };
        foreach (vecs[i]) send(vecs[i].t, vecs[i].f, vecs[i].sh, vecs[i].a, vecs[i].b, vecs[i].eop);
        idle(3);

        // 5: flush in FULL together with in_valid
        out_ready = 1'b0;
        send(3'b000, 6'h00, 5'd0, 32'h100, 32'h200, 4'b0011);
        send(3'b011, 6'h00, 5'd0, 32'h300, 32'h400, 4'b0001);
        flush = 1'b1;
        alu_op_type = 3'b100;
        a_in = 32'hDEAD;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_alu_operation", {28'd0, alu_operation}, 32'hF);
        chk("flush_a_out", a_out, 32'd0);
        @(negedge clk);
        chk("flush_no_capture", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // 6: slt is unsupported
        out_ready = 1'b1;
        send(3'b010, 6'h2A, 5'd0, 32'h21, 32'h22, 4'hF);
        @(negedge clk);
        chk("slt_alu_operation", {28'd0, alu_operation}, 32'hF);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("slt_illegal_op", {31'd0, illegal_op}, 32'd1);
`endif
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
        chk("illegal_seen_sticky", {31'd0, illegal_seen}, 32'd1);
`endif
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
